alpha_cell_shifter: RTL and testbench
=====================================

Name: alpha_cell_shifter

Overview:
Parametrised successor to the alphanumeric row switch in the 6847 replacement pixel path. Accepts one character cell per handshake: code, mode, inversion, colour and scan row. It fetches the glyph row from an external character ROM and builds the 8-pixel row pattern for alpha, SG4 or SG6 modes. It then serialises the pattern MSB-first at a programmable pixel rate as 9-bit RGB. A one-deep holding stage lets consecutive cells stream with no pixel gap.

Parameters:
GLYPH_W, 8, pixels per cell and ROM data width
GLYPH_ROWS, 7, active glyph rows in alpha mode
TOP_PAD, 3, blank rows above the glyph in alpha mode
CELL_ROWS, 12, scan rows per cell; must be divisible by 2 and 3
DIV_W, 2, width of divider; pixel period = divider+1 clocks

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
load  in  1  cell request; accepted when load && ready
ready  out  1  holding stage empty
code  in  6  character code (alpha) or block bits (SG)
inv  in  1  alpha inversion; ignored in SG modes
sg_mode  in  2  00 alpha, 01 SG4, 10 SG6, 11 treated as alpha
sg_color  in  3  SG foreground palette index
css  in  1  alpha colour set select
row  in  4  scan row within cell, 0..CELL_ROWS-1
divider  in  DIV_W  pixel period minus one, latched per cell
rom_char  out  6  ROM character address, registered
rom_row  out  3  ROM glyph row address, registered
rom_data  in  GLYPH_W  ROM row data, valid one cycle after address
rgb  out  9  pixel colour, {R[2:0],G[2:0],B[2:0]}
pixel_valid  out  1  rgb carries cell pixels
cell_done  out  1  one-cycle pulse with the last clock of a cell's last pixel

Behaviour:
- Reset (reset_n=0 at an edge): ready=1, pixel_valid=0, rgb=0, cell_done=0, rom_char=0, rom_row=0. Pipeline, holding stage and shifter are cleared. A cell that is mid-shift is aborted with no cell_done.
- Pipeline stages:
  - Accept edge E0: register code/mode/inv/colour/css/row/divider; drive rom_char=code and rom_row=(row-TOP_PAD)[2:0].
  - E1: sample rom_data, form the pattern and the fg/bg colours, and write them to the holding stage.
  - The holding stage loads into the shifter at the later of E2 and the end of the current cell.
  - With an idle shifter, the first pixel shows on rgb with pixel_valid=1 from E2.
- ready=0 from acceptance until the holding stage transfers to the shifter. There is at most one cell in fetch or holding at a time.
- Shifter states: IDLE and SHIFT. In SHIFT, each pixel is held divider+1 clocks and there are GLYPH_W pixels per cell.
  - After the last pixel, load the held pattern if one is present, with no gap and pixel_valid kept at 1.
  - Otherwise go to IDLE with pixel_valid=0 and rgb=0.
- Alpha pattern:
  - If row<TOP_PAD or row>=TOP_PAD+GLYPH_ROWS, the pattern is all zeros; otherwise it is rom_data.
  - XOR the pattern with all ones when inv=1.
  - Colours for css=0: fg 000_111_000, bg 000_010_000. Colours for css=1: fg 111_100_000, bg 010_001_000.
- SG4 pattern: the left half is bit3 and the right half bit2 for row<CELL_ROWS/2; otherwise bit1 and bit0. Each half is GLYPH_W/2 pixels.
- SG6 pattern:
  - Thirds of CELL_ROWS select the bit pairs (5,4), (3,2), (1,0), each as left,right halves.
  - SG fg palette by sg_color: 0 green 000_111_000, 1 yellow 111_111_000, 2 blue 000_000_111, 3 red 111_000_000, 4 buff 111_111_101, 5 cyan 000_111_111, 6 magenta 111_000_111, 7 orange 111_100_000.
  - SG bg is 000_000_000.
- row>=CELL_ROWS in any mode: the pattern is all zeros (bg colour); inv still applies in alpha mode.
- Pattern bit 1 gives fg and bit 0 gives bg. Output is MSB first.
- A divider change mid-cell has no effect until the next cell's latch.
- Load with ready=0 is ignored, with no side effect.
- Simultaneous accept and cell end: the current cell completes normally and the new cell follows per the pipeline timing above.

Test Plan:
- Alpha, divider=0, row=2, inv=0, css=0: 8 clocks rgb=000_010_000, pixel_valid=1 from E2, cell_done on the 8th clock.
- Alpha, row=5, rom_data=8'hA5, inv=1, css=1, divider=1: pixels bg,fg,bg,fg,fg,bg,fg,bg (pattern 5A), each held 2 clocks, rom_row=2.
- SG6, code=6'b011000, sg_color=3, row=5, divider=0: 4 pixels 111_000_000 then 4 pixels 000_000_000.
- Back-to-back: accept cell A, then cell B 2 clocks later, divider=0: 16 consecutive valid pixels, no gap, ready=0 while B waits, two cell_done pulses.
- Starvation: single cell then no load: pixel_valid drops to 0 and rgb=0 the clock after the last pixel; a load while ready=0 is dropped.
- reset_n=0 mid-cell at pixel 3: the next clock gives pixel_valid=0, rgb=0, ready=1, no cell_done; a fresh load afterwards gives correct timing from E2.

Source files
------------

// File: rtl/alpha_cell_shifter.sv
// Character-cell pixel generator: ROM row fetch, alpha/SG4/SG6 pattern build, MSB-first serialiser.
// First pixel two clocks after accept; ready drops until the held cell enters the shifter.
module alpha_cell_shifter #(
    parameter int GLYPH_W    = 8,
    parameter int GLYPH_ROWS = 7,
    parameter int TOP_PAD    = 3,
    parameter int CELL_ROWS  = 12,
    parameter int DIV_W      = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    output logic               ready,
    input  logic [5:0]         code,
    input  logic               inv,
    input  logic [1:0]         sg_mode,
    input  logic [2:0]         sg_color,
    input  logic               css,
    input  logic [3:0]         row,
    input  logic [DIV_W-1:0]   divider,
    output logic [5:0]         rom_char,
    output logic [2:0]         rom_row,
    input  logic [GLYPH_W-1:0] rom_data,
    output logic [8:0]         rgb,
    output logic               pixel_valid,
    output logic               cell_done
);

    localparam int HALF  = GLYPH_W / 2;
    localparam int RHALF = GLYPH_W - HALF;
    localparam int PW    = $clog2(GLYPH_W);

    localparam logic [3:0] PAD4      = 4'(TOP_PAD);
    localparam logic [4:0] PAD5      = 5'(TOP_PAD);
    localparam logic [4:0] GLY_END5  = 5'(TOP_PAD + GLYPH_ROWS);
    localparam logic [4:0] ROWS5     = 5'(CELL_ROWS);
    localparam logic [4:0] SG4_SPLIT = 5'(CELL_ROWS / 2);
    localparam logic [4:0] SG6_A     = 5'(CELL_ROWS / 3);
    localparam logic [4:0] SG6_B     = 5'(2 * CELL_ROWS / 3);

    localparam logic [PW-1:0]    PIX_LAST = PW'(GLYPH_W - 1);
    localparam logic [PW-1:0]    PIX_ONE  = PW'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [8:0] ALPHA_FG0 = 9'b000_111_000;
    localparam logic [8:0] ALPHA_BG0 = 9'b000_010_000;
    localparam logic [8:0] ALPHA_FG1 = 9'b111_100_000;
    localparam logic [8:0] ALPHA_BG1 = 9'b010_001_000;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic logic [8:0] sg_palette(input logic [2:0] c);
        case (c)
            3'd0:    return 9'b000_111_000;
            3'd1:    return 9'b111_111_000;
            3'd2:    return 9'b000_000_111;
            3'd3:    return 9'b111_000_000;
            3'd4:    return 9'b111_111_101;
            3'd5:    return 9'b000_111_111;
            3'd6:    return 9'b111_000_111;
            default: return 9'b111_100_000;
        endcase
    endfunction

    function automatic logic [GLYPH_W-1:0] half_pat(input logic l, input logic r);
        return {{HALF{l}}, {RHALF{r}}};
    endfunction

    // Fetch stage; rom_char doubles as the latched code for the SG modes.
    logic             f_vld;
    logic             f_inv;
    logic [1:0]       f_mode;
    logic [2:0]       f_color;
    logic             f_css;
    logic [3:0]       f_row;
    logic [DIV_W-1:0] f_div;
    logic [3:0]       row_off;
    logic [4:0]       row5;
    logic             accept;

    // Holding stage
    logic               hold_vld;
    logic [GLYPH_W-1:0] hold_pat;
    logic [8:0]         hold_fg;
    logic [8:0]         hold_bg;
    logic [DIV_W-1:0]   hold_div;

    // Shifter
    state_t             state_q;
    state_t             state_d;
    logic [GLYPH_W-1:0] pat_q;
    logic [8:0]         fg_q;
    logic [8:0]         bg_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [PW-1:0]      pix_cnt_q;
    logic               last_clk;
    logic               cell_end;
    logic               take;

    logic [GLYPH_W-1:0] pat_d;
    logic [8:0]         fg_d;
    logic [8:0]         bg_d;

    assign ready   = ~(f_vld | hold_vld);
    assign accept  = load & ready;
    assign row_off = row - PAD4;
    assign row5    = {1'b0, f_row};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            f_vld    <= 1'b0;
            rom_char <= '0;
            rom_row  <= '0;
            f_inv    <= 1'b0;
            f_mode   <= '0;
            f_color  <= '0;
            f_css    <= 1'b0;
            f_row    <= '0;
            f_div    <= '0;
        end else begin
            f_vld <= accept;
            if (accept) begin
                rom_char <= code;
                rom_row  <= row_off[2:0];
                f_inv    <= inv;
                f_mode   <= sg_mode;
                f_color  <= sg_color;
                f_css    <= css;
                f_row    <= row;
                f_div    <= divider;
            end
        end
    end

    always_comb begin
        pat_d = '0;
        fg_d  = ALPHA_FG0;
        bg_d  = ALPHA_BG0;
        case (f_mode)
            2'b01: begin
                fg_d = sg_palette(f_color);
                bg_d = '0;
                if (row5 < ROWS5)
                    pat_d = (row5 < SG4_SPLIT) ? half_pat(rom_char[3], rom_char[2])
                                               : half_pat(rom_char[1], rom_char[0]);
            end
            2'b10: begin
                fg_d = sg_palette(f_color);
                bg_d = '0;
                if (row5 < SG6_A)
                    pat_d = half_pat(rom_char[5], rom_char[4]);
                else if (row5 < SG6_B)
                    pat_d = half_pat(rom_char[3], rom_char[2]);
                else if (row5 < ROWS5)
                    pat_d = half_pat(rom_char[1], rom_char[0]);
            end
            default: begin
                if (f_css) begin
                    fg_d = ALPHA_FG1;
                    bg_d = ALPHA_BG1;
                end
                if (row5 >= PAD5 && row5 < GLY_END5 && row5 < ROWS5)
                    pat_d = rom_data;
                // Inversion also applies to blank pad rows.
                if (f_inv)
                    pat_d = ~pat_d;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_vld <= 1'b0;
            hold_pat <= '0;
            hold_fg  <= '0;
            hold_bg  <= '0;
            hold_div <= '0;
        end else if (f_vld) begin
            hold_vld <= 1'b1;
            hold_pat <= pat_d;
            hold_fg  <= fg_d;
            hold_bg  <= bg_d;
            hold_div <= f_div;
        end else if (take) begin
            hold_vld <= 1'b0;
        end
    end

    assign last_clk = (div_cnt_q == div_q);
    assign cell_end = (state_q == SHIFT) && last_clk && (pix_cnt_q == PIX_LAST);
    assign take     = hold_vld && ((state_q == IDLE) || cell_end);

    always_comb begin
        state_d     = state_q;
        pixel_valid = 1'b0;
        rgb         = '0;
        cell_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (take)
                    state_d = SHIFT;
            end
            default: begin
                pixel_valid = 1'b1;
                rgb         = pat_q[GLYPH_W-1] ? fg_q : bg_q;
                cell_done   = cell_end;
                if (cell_end && !take)
                    state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            fg_q      <= '0;
            bg_q      <= '0;
            div_q     <= '0;
            div_cnt_q <= '0;
            pix_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                pat_q     <= hold_pat;
                fg_q      <= hold_fg;
                bg_q      <= hold_bg;
                div_q     <= hold_div;
                div_cnt_q <= '0;
                pix_cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                if (last_clk) begin
                    div_cnt_q <= '0;
                    pix_cnt_q <= pix_cnt_q + PIX_ONE;
                    pat_q     <= {pat_q[GLYPH_W-2:0], 1'b0};
                end else begin
                    div_cnt_q <= div_cnt_q + DIV_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alpha_cell_shifter.sv
// Directed vector bench for alpha_cell_shifter with a combinational character ROM model.
module tb_alpha_cell_shifter;

    logic       clk;
    logic       reset_n;
    logic       load;
    logic       ready;
    logic [5:0] code;
    logic       inv;
    logic [1:0] sg_mode;
    logic [2:0] sg_color;
    logic       css;
    logic [3:0] row;
    logic [1:0] divider;
    logic [5:0] rom_char;
    logic [2:0] rom_row;
    logic [7:0] rom_data;
    logic [8:0] rgb;
    logic       pixel_valid;
    logic       cell_done;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [8:0] GRN  = 9'b000_111_000;
    localparam logic [8:0] ABG0 = 9'b000_010_000;
    localparam logic [8:0] AFG1 = 9'b111_100_000;
    localparam logic [8:0] ABG1 = 9'b010_001_000;
    localparam logic [8:0] BLK  = 9'b000_000_000;

    alpha_cell_shifter dut (
        .clk(clk), .reset_n(reset_n), .load(load), .ready(ready),
        .code(code), .inv(inv), .sg_mode(sg_mode), .sg_color(sg_color),
        .css(css), .row(row), .divider(divider),
        .rom_char(rom_char), .rom_row(rom_row), .rom_data(rom_data),
        .rgb(rgb), .pixel_valid(pixel_valid), .cell_done(cell_done)
    );

    // ROM model: data = {char[4:0], ~row}
    assign rom_data = {rom_char[4:0], rom_row ^ 3'b111};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] code;
        logic       inv;
        logic [1:0] mode;
        logic [2:0] color;
        logic       css;
        logic [3:0] row;
        logic [1:0] div;
        logic [7:0] pat;
        logic [8:0] fg;
        logic [8:0] bg;
        logic [2:0] rrow;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        code     = v.code;
        inv      = v.inv;
        sg_mode  = v.mode;
        sg_color = v.color;
        css      = v.css;
        row      = v.row;
        divider  = v.div;
    endtask

    task automatic scramble();
        code     = code ^ 6'h3F;
        inv      = ~inv;
        sg_mode  = sg_mode ^ 2'b11;
        sg_color = sg_color ^ 3'b111;
        css      = ~css;
        row      = row ^ 4'hF;
        divider  = ~divider;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ready !== 1'b1 || pixel_valid !== 1'b0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (n >= 60) begin
            n_vec++;
            n_bad++;
            $display("FAIL idle_timeout: got busy expected idle within 60 clocks");
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        wait_idle();
        @(negedge clk);
        drive(v);
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        scramble();
        chk($sformatf("v%0d rom_char", idx), 32'(rom_char), 32'(v.code));
        chk($sformatf("v%0d rom_row", idx), 32'(rom_row), 32'(v.rrow));
        chk($sformatf("v%0d ready_e0", idx), 32'(ready), 32'd0);
        chk($sformatf("v%0d pv_e0", idx), 32'(pixel_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d pv_e1", idx), 32'(pixel_valid), 32'd0);
        chk($sformatf("v%0d ready_e1", idx), 32'(ready), 32'd0);
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d <= int'(v.div); d++) begin
                @(negedge clk);
                chk($sformatf("v%0d p%0d.%0d pv", idx, i, d), 32'(pixel_valid), 32'd1);
                chk($sformatf("v%0d p%0d.%0d rgb", idx, i, d), 32'(rgb),
                    32'(v.pat[7-i] ? v.fg : v.bg));
                chk($sformatf("v%0d p%0d.%0d done", idx, i, d), 32'(cell_done),
                    32'((i == 7 && d == int'(v.div)) ? 1 : 0));
                chk($sformatf("v%0d p%0d.%0d ready", idx, i, d), 32'(ready), 32'd1);
                @(posedge clk);
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d pv_after", idx), 32'(pixel_valid), 32'd0);
        chk($sformatf("v%0d rgb_after", idx), 32'(rgb), 32'd0);
        chk($sformatf("v%0d done_after", idx), 32'(cell_done), 32'd0);
    endtask

    initial begin
        vec_t a;
        vec_t b;
        logic [8:0] exp_rgb;

        //            code  inv mode col css row div  pat    fg                bg    rrow
        tbl[0]  = '{6'h01, 1'b0, 2'd0, 3'd0, 1'b0, 4'd2,  2'd0, 8'h00, GRN,          ABG0, 3'd7};
        tbl[1]  = '{6'h14, 1'b1, 2'd0, 3'd0, 1'b1, 4'd5,  2'd1, 8'h5A, AFG1,         ABG1, 3'd2};
        tbl[2]  = '{6'h18, 1'b0, 2'd2, 3'd3, 1'b0, 4'd5,  2'd0, 8'hF0, 9'b111000000, BLK,  3'd2};
        tbl[3]  = '{6'h04, 1'b1, 2'd1, 3'd5, 1'b1, 4'd3,  2'd0, 8'h0F, 9'b000111111, BLK,  3'd0};
        tbl[4]  = '{6'h02, 1'b0, 2'd1, 3'd6, 1'b0, 4'd8,  2'd2, 8'hF0, 9'b111000111, BLK,  3'd5};
        tbl[5]  = '{6'h3F, 1'b0, 2'd0, 3'd0, 1'b0, 4'd11, 2'd0, 8'h00, GRN,          ABG0, 3'd0};
        tbl[6]  = '{6'h3F, 1'b1, 2'd0, 3'd0, 1'b0, 4'd12, 2'd0, 8'hFF, GRN,          ABG0, 3'd1};
        tbl[7]  = '{6'h3F, 1'b0, 2'd2, 3'd4, 1'b0, 4'd12, 2'd0, 8'h00, 9'b111111101, BLK,  3'd1};
        tbl[8]  = '{6'h0F, 1'b0, 2'd3, 3'd0, 1'b0, 4'd3,  2'd0, 8'h7F, GRN,          ABG0, 3'd0};
        tbl[9]  = '{6'h01, 1'b0, 2'd2, 3'd7, 1'b1, 4'd9,  2'd3, 8'h0F, 9'b111100000, BLK,  3'd6};
        tbl[10] = '{6'h20, 1'b0, 2'd2, 3'd1, 1'b0, 4'd0,  2'd0, 8'hF0, 9'b111111000, BLK,  3'd5};
        tbl[11] = '{6'h15, 1'b0, 2'd0, 3'd0, 1'b1, 4'd9,  2'd0, 8'hA9, AFG1,         ABG1, 3'd6};
        tbl[12] = '{6'h00, 1'b1, 2'd0, 3'd0, 1'b0, 4'd3,  2'd0, 8'hF8, GRN,          ABG0, 3'd0};

        reset_n = 1'b0;
        load    = 1'b0;
        drive(tbl[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst pv", 32'(pixel_valid), 32'd0);
        chk("rst rgb", 32'(rgb), 32'd0);
        chk("rst done", 32'(cell_done), 32'd0);
        chk("rst rom_char", 32'(rom_char), 32'd0);
        chk("rst rom_row", 32'(rom_row), 32'd0);
        reset_n = 1'b1;

        for (int k = 0; k < 13; k++)
            run_vec(k, tbl[k]);

        // Back-to-back: B is presented continuously; early attempts are dropped.
        a = '{6'h01, 1'b1, 2'd0, 3'd0, 1'b0, 4'd2, 2'd0, 8'hFF, GRN, ABG0, 3'd7};
        b = tbl[2];
        wait_idle();
        @(negedge clk);
        drive(a);
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(b);
        chk("b2b ready_e0", 32'(ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b dropped rom_char", 32'(rom_char), 32'(a.code));
        chk("b2b ready_e1", 32'(ready), 32'd0);
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 1)
                load = 1'b0;
            exp_rgb = (i < 8) ? GRN : ((i < 12) ? 9'b111000000 : BLK);
            chk($sformatf("b2b p%0d pv", i), 32'(pixel_valid), 32'd1);
            chk($sformatf("b2b p%0d rgb", i), 32'(rgb), 32'(exp_rgb));
            chk($sformatf("b2b p%0d done", i), 32'(cell_done), 32'((i == 7 || i == 15) ? 1 : 0));
            chk($sformatf("b2b p%0d ready", i), 32'(ready), 32'((i == 0 || i >= 8) ? 1 : 0));
            @(posedge clk);
        end
        @(negedge clk);
        chk("starve pv", 32'(pixel_valid), 32'd0);
        chk("starve rgb", 32'(rgb), 32'd0);

        // Reset at pixel 3 of A while B sits in the holding stage.
        wait_idle();
        @(negedge clk);
        drive(tbl[0]);
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(b);
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1)
                load = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        chk("mid pv_p3", 32'(pixel_valid), 32'd1);
        chk("mid ready_p3", 32'(ready), 32'd0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid rst pv", 32'(pixel_valid), 32'd0);
        chk("mid rst rgb", 32'(rgb), 32'd0);
        chk("mid rst ready", 32'(ready), 32'd1);
        chk("mid rst done", 32'(cell_done), 32'd0);
        chk("mid rst rom_char", 32'(rom_char), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("post rst %0d pv", i), 32'(pixel_valid), 32'd0);
            chk($sformatf("post rst %0d done", i), 32'(cell_done), 32'd0);
            @(posedge clk);
        end
        run_vec(100, tbl[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
